// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, constants and lane-merge helper for dmem_arbiter
//
// Contents:
//   state_t     arbiter sequencing states
//   owner_t     which requester holds the in-flight transaction
//   BE_FULL     all-ones byte-enable pattern; slice to the real BE width
//   byte_merge  one byte lane of a read-modify-write merge
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_t;

    // Wide enough for any sensible DATA_W; users take the low BE_W bits.
    localparam logic [63:0] BE_FULL = '1;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// rtl/dmem_byte_merge.sv - combinational per-lane merge of store data into an old RAM word
//
// Ports:
//   old_word     in   DATA_W    word captured from RAM
//   new_word     in   DATA_W    store data, lanes aligned to the word
//   be           in   DATA_W/8  byte enables, 1 = take the new_word lane
//   merged_word  out  DATA_W    word to be written back
module dmem_byte_merge
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged_word
);

    for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
        assign merged_word[8*i +: 8] = byte_merge(old_word[8*i +: 8], new_word[8*i +: 8], be[i]);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and access sequencer for a word-wide data RAM
//
// Arbitrates P0 (core LSU) and P1 (loader/debug) onto one RAM with combinational read
// and posedge write, running one transaction at a time. Sub-word stores become a
// read-modify-write since the RAM has no byte enables.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   pN_req/we/addr/wdata/be       requester N command, held stable until pN_gnt
//   pN_gnt                        one-cycle completion pulse
//   pN_rdata                      read data, valid while pN_gnt is high (0 for writes)
//   mem_we/mem_a/mem_wd           RAM write enable, word address, write data
//   mem_rd                        RAM read data (combinational from mem_a)
//
// Build option: DMEM_ARB_RR_EN selects round-robin on simultaneous requests;
// without it P0 has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_be,
    output logic                p0_gnt,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_be,
    output logic                p1_gnt,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [DATA_W-1:0]   mem_wd,
    input  logic [DATA_W-1:0]   mem_rd
);

    localparam int BE_W = DATA_W / 8;

    state_t              state, state_nxt;
    owner_t              owner, win;
    logic                lat_we;
    logic [ADDR_W-3:0]   lat_word;
    logic [DATA_W-1:0]   lat_wdata;
    logic [BE_W-1:0]     lat_be;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   merge_q;
    logic [DATA_W-1:0]   merged;

    logic                any_req;
    logic                win_we;
    logic [ADDR_W-3:0]   win_word;
    logic [DATA_W-1:0]   win_wdata;
    logic [BE_W-1:0]     win_be;
    logic [ADDR_W-1:0]   word_addr;

    // Byte offset bits are ignored: all RAM accesses are whole words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[1:0], p1_addr[1:0]};

    assign any_req   = p0_req | p1_req;
    assign word_addr = {lat_word, 2'b00};

`ifdef DMEM_ARB_RR_EN
    owner_t last_owner;

    always_comb begin
        win = OWN_P0;
        if (p0_req && p1_req) begin
            win = (last_owner == OWN_P0) ? OWN_P1 : OWN_P0;
        end else if (p1_req) begin
            win = OWN_P1;
        end
    end

    // Reset to P1 so that the first contest after reset goes to P0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWN_P1;
        end else if (state == S_IDLE && any_req) begin
            last_owner <= win;
        end
    end
`else
    always_comb begin
        win = OWN_P0;
        if (!p0_req && p1_req) begin
            win = OWN_P1;
        end
    end
`endif

    always_comb begin
        if (win == OWN_P1) begin
            win_we    = p1_we;
            win_word  = p1_addr[ADDR_W-1:2];
            win_wdata = p1_wdata;
            win_be    = p1_be;
        end else begin
            win_we    = p0_we;
            win_word  = p0_addr[ADDR_W-1:2];
            win_wdata = p0_wdata;
            win_be    = p0_be;
        end
    end

    // For full-word writes merge_q is stale, but every lane takes lat_wdata.
    dmem_byte_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_word    (merge_q),
        .new_word    (lat_wdata),
        .be          (lat_be),
        .merged_word (merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner     <= OWN_P0;
            lat_we    <= 1'b0;
            lat_word  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata_q   <= '0;
            merge_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && any_req) begin
                owner     <= win;
                lat_we    <= win_we;
                lat_word  <= win_word;
                lat_wdata <= win_wdata;
                lat_be    <= win_be;
            end
            if (state == S_RD) begin
                rdata_q <= mem_rd;
            end
            if (state == S_RMW_RD) begin
                merge_q <= mem_rd;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    if (!win_we) begin
                        state_nxt = S_RD;
                    end else if (win_be == '0) begin
                        state_nxt = S_DONE;
                    end else if (win_be == BE_FULL[BE_W-1:0]) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                mem_a     = word_addr;
                state_nxt = S_DONE;
            end
            S_RMW_RD: begin
                mem_a     = word_addr;
                state_nxt = S_WR;
            end
            S_WR: begin
                mem_a     = word_addr;
                mem_we    = 1'b1;
                mem_wd    = merged;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (owner == OWN_P1) begin
                    p1_gnt   = 1'b1;
                    p1_rdata = lat_we ? '0 : rdata_q;
                end else begin
                    p0_gnt   = 1'b1;
                    p0_rdata = lat_we ? '0 : rdata_q;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
